art_msg_streamer: RTL and testbench

//  Downstream consumer of the latched ui_in command byte in the silicon-art tile.
//  On a start command, streams a fixed ASCII message (the die's art text) byte-by-byte

---
 rtl/art_msg_streamer_if.sv | 32 +++
 rtl/art_msg_streamer.sv | 200 ++++++++++++++++++++
 tb/tb_art_msg_streamer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/art_msg_streamer_if.sv
// art_msg_streamer_if: command strobe plus valid/ready byte stream of the
// silicon-art message streamer. The master side issues commands and accepts
// bytes. The slave side is the streamer itself.
interface art_msg_streamer_if;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    modport master (
        output cmd,
        output cmd_valid,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd,
        input  cmd_valid,
        input  out_ready,
        output out_data,
        output out_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/art_msg_streamer.sv
// art_msg_streamer: on a start command, streams the fixed art message
// byte-by-byte over a valid/ready port, with an optional inter-byte gap and
// an optional looping mode. The output is all-zero whenever no byte is valid.
//
// Build option: define ART_CRC_EN to append a CRC-8 byte to every pass.
// The CRC uses poly 0x07, init 0x00, no reflection and no xorout. It covers the
// message bytes of that pass. With the macro undefined, a pass is exactly
// MSG_LEN bytes and no CRC logic exists.
module art_msg_streamer #(
    parameter int                   MSG_LEN = 4,
    parameter logic [8*MSG_LEN-1:0] MSG     = 32'h41_52_54_21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    art_msg_streamer_if.slave bus
);

    localparam int IDX_W = $clog2(MSG_LEN + 1);
    localparam logic [IDX_W-1:0] LEN_IDX = IDX_W'(MSG_LEN);
`ifdef ART_CRC_EN
    // The CRC byte occupies slot MSG_LEN, so it is the last byte of a pass.
    localparam logic [IDX_W-1:0] LAST_IDX = LEN_IDX;
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [3:0]       gap;
    logic [3:0]       gap_cnt;
    logic             loop;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic             start_cmd;
    logic             stop_cmd;
    logic             xfer;
    logic             last;
    logic [7:0]       nxt_byte;
    logic [7:0]       cur_byte;
    logic             unused_rsvd;

`ifdef ART_CRC_EN
    logic [7:0]       crc;
    logic [7:0]       crc_upd;
    logic [7:0]       nxt_crc;
`endif

    // Message byte i, with byte 0 taken from the MSB end of MSG. Any slot
    // outside the message reads as zero.
    function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] i);
        logic [7:0] b;
        b = '0;
        for (int unsigned k = 0; k < MSG_LEN; k++) begin
            if (i == IDX_W'(k)) begin
                b = MSG[8*(MSG_LEN-1-k) +: 8];
            end
        end
        return b;
    endfunction

`ifdef ART_CRC_EN
    // One byte of CRC-8, poly 0x07, processed MSB first.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int unsigned b = 0; b < 8; b++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction
`endif

    // Decode the command strobe, detect transfers, and select the next byte to present.
    always_comb begin
        start_cmd = bus.cmd_valid && bus.cmd[0];
        stop_cmd  = bus.cmd_valid && !bus.cmd[0];
        xfer      = valid_q && bus.out_ready;
        last      = (idx == LAST_IDX);
        nxt_idx   = last ? '0 : idx + 1'b1;
`ifdef ART_CRC_EN
        // The CRC of the byte being transferred must be folded in. Otherwise a
        // back-to-back CRC byte would miss the final message byte.
        crc_upd   = crc8_step(crc, data_q);
        nxt_crc   = last ? '0 : crc_upd;
        nxt_byte  = (nxt_idx == LEN_IDX) ? nxt_crc : msg_byte(nxt_idx);
        cur_byte  = (idx == LEN_IDX) ? crc : msg_byte(idx);
`else
        nxt_byte  = msg_byte(nxt_idx);
        cur_byte  = msg_byte(idx);
`endif
    end

    assign unused_rsvd = ^bus.cmd[3:2];

    // Streamer FSM. Every output is registered. When ena is low, everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            gap     <= '0;
            gap_cnt <= '0;
            loop    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ART_CRC_EN
            crc     <= '0;
`endif
        end else if (ena) begin
            done_q <= 1'b0;
            if (stop_cmd && state != IDLE) begin
                // An abort takes priority over a transfer in the same cycle, and it suppresses done.
                state   <= IDLE;
                idx     <= '0;
                gap_cnt <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_cmd) begin
                            loop    <= bus.cmd[1];
                            gap     <= bus.cmd[7:4];
                            idx     <= '0;
                            state   <= SEND;
                            data_q  <= msg_byte('0);
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
`ifdef ART_CRC_EN
                            crc     <= '0;
`endif
                        end
                    end
                    SEND: begin
                        if (xfer) begin
`ifdef ART_CRC_EN
                            crc <= nxt_crc;
`endif
                            if (last) begin
                                done_q <= 1'b1;
                            end
                            if (last && !loop) begin
                                state   <= IDLE;
                                idx     <= '0;
                                data_q  <= '0;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end else begin
                                idx <= nxt_idx;
                                if (gap != '0) begin
                                    state   <= GAP;
                                    gap_cnt <= gap;
                                    data_q  <= '0;
                                    valid_q <= 1'b0;
                                end else begin
                                    data_q <= nxt_byte;
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == 4'd1) begin
                            state   <= SEND;
                            gap_cnt <= '0;
                            data_q  <= cur_byte;
                            valid_q <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        data_q  <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_art_msg_streamer.sv
// tb_art_msg_streamer: scoreboard bench for art_msg_streamer. Expected bytes
// are queued when a command is issued, then popped on each observed transfer.
// Outputs are sampled on the falling clock edge, and inputs are driven right after.
`timescale 1ns/1ps
module tb_art_msg_streamer;

    localparam int MSG_LEN = 4;
`ifdef ART_CRC_EN
    localparam int PASS_LEN = MSG_LEN + 1;
`else
    localparam int PASS_LEN = MSG_LEN;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;

    art_msg_streamer_if bus ();

    art_msg_streamer #(
        .MSG_LEN (MSG_LEN),
        .MSG     (32'h41_52_54_21)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb [$];
    logic [7:0] msg_bytes [MSG_LEN] = '{8'h41, 8'h52, 8'h54, 8'h21};

`ifdef ART_CRC_EN
    function automatic logic [7:0] model_crc();
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < MSG_LEN; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ msg_bytes[i][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction
`endif

    function automatic logic [7:0] exp_byte(input int k);
`ifdef ART_CRC_EN
        if (k >= MSG_LEN) return model_crc();
`endif
        return msg_bytes[k];
    endfunction

    task automatic push_bytes(input int n);
        for (int k = 0; k < n; k++) sb.push_back(exp_byte(k % PASS_LEN));
    endtask

    task automatic pop_exp(output logic [7:0] b, output bit ok);
        ok = (sb.size() != 0);
        b  = 8'h00;
        if (ok) b = sb.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        bus.cmd = '0;
        bus.cmd_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b data=%h busy=%b done=%b exp all 0",
                     bus.out_valid, bus.out_data, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got valid=%b busy=%b exp 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_basic();
        int last_x = 0, nx = 0, done_cyc = -1;
        logic [7:0] e;
        bit ok;
        sb.delete();
        push_bytes(PASS_LEN);
        bus.out_ready = 1'b1;
        bus.cmd = 8'h01;
        bus.cmd_valid = 1'b1;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                checks++;
                if (cyc != last_x + 1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_done got cycle=%0d busy=%b valid=%b exp cycle=%0d busy=0 valid=0",
                             cyc, bus.busy, bus.out_valid, last_x + 1);
                end
            end else if (bus.out_valid === 1'b1) begin
                pop_exp(e, ok);
                checks++;
                if (!ok || bus.out_data !== e || cyc != last_x + 1) begin
                    failures++;
                    $display("FAIL basic_byte got data=%h cycle=%0d exp data=%h cycle=%0d",
                             bus.out_data, cyc, e, last_x + 1);
                end
                last_x = cyc;
                nx++;
            end
        end
        checks++;
        if (done_cyc < 0 || nx != PASS_LEN) begin
            failures++;
            $display("FAIL basic_count got bytes=%0d done_cycle=%0d exp bytes=%0d with done", nx, done_cyc, PASS_LEN);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got done=%b exp 0", bus.done);
        end
    endtask

    task automatic test_gap();
        int last_x = 0, nx = 0, done_cyc = -1;
        logic [7:0] e;
        bit ok;
        sb.delete();
        push_bytes(PASS_LEN);
        bus.out_ready = 1'b1;
        bus.cmd = 8'h31;
        bus.cmd_valid = 1'b1;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                checks++;
                if (cyc != last_x + 1 || bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_done got cycle=%0d busy=%b exp cycle=%0d busy=0", cyc, bus.busy, last_x + 1);
                end
            end else if (bus.out_valid === 1'b1) begin
                pop_exp(e, ok);
                checks++;
                if (!ok || bus.out_data !== e || cyc != (nx == 0 ? 1 : last_x + 4)) begin
                    failures++;
                    $display("FAIL gap_byte got data=%h cycle=%0d exp data=%h cycle=%0d",
                             bus.out_data, cyc, e, (nx == 0 ? 1 : last_x + 4));
                end
                last_x = cyc;
                nx++;
            end else begin
                checks++;
                if (bus.out_data !== 8'h00) begin
                    failures++;
                    $display("FAIL gap_idle_data got %h exp 00", bus.out_data);
                end
            end
        end
        checks++;
        if (done_cyc < 0 || nx != PASS_LEN) begin
            failures++;
            $display("FAIL gap_count got bytes=%0d done_cycle=%0d exp bytes=%0d with done", nx, done_cyc, PASS_LEN);
        end
    endtask

    task automatic test_backpressure();
        int nx = 0, hold_left = 0, done_cyc = -1;
        bit held = 0;
        logic [7:0] e;
        bit ok;
        sb.delete();
        push_bytes(PASS_LEN);
        bus.out_ready = 1'b1;
        bus.cmd = 8'h01;
        bus.cmd_valid = 1'b1;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (hold_left == 0 && !held && bus.out_valid === 1'b1 && bus.out_data === 8'h52) hold_left = 5;
            if (bus.done === 1'b1) done_cyc = cyc;
            if (hold_left > 0) begin
                bus.out_ready = 1'b0;
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h52) begin
                    failures++;
                    $display("FAIL bp_hold got valid=%b data=%h exp valid=1 data=52", bus.out_valid, bus.out_data);
                end
                hold_left--;
                if (hold_left == 0) held = 1;
            end else begin
                bus.out_ready = 1'b1;
                if (bus.out_valid === 1'b1) begin
                    pop_exp(e, ok);
                    checks++;
                    if (!ok || bus.out_data !== e) begin
                        failures++;
                        $display("FAIL bp_byte got %h exp %h", bus.out_data, e);
                    end
                    nx++;
                end
            end
        end
        bus.out_ready = 1'b1;
        checks++;
        if (!held || done_cyc < 0 || nx != PASS_LEN || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_count got bytes=%0d held=%0d done_cycle=%0d exp bytes=%0d held=1 with done",
                     nx, held, done_cyc, PASS_LEN);
        end
    endtask

    task automatic test_loop_abort();
        int nx = 0, ndone = 0;
        bit quiet = 1;
        logic [7:0] e;
        bit ok;
        sb.delete();
        push_bytes(9);
        bus.out_ready = 1'b1;
        bus.cmd = 8'h03;
        bus.cmd_valid = 1'b1;
        for (int cyc = 1; cyc <= 40 && nx < 9; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (bus.done === 1'b1) ndone++;
            if (bus.out_valid === 1'b1) begin
                pop_exp(e, ok);
                checks++;
                if (!ok || bus.out_data !== e) begin
                    failures++;
                    $display("FAIL loop_byte got %h exp %h (transfer %0d)", bus.out_data, e, nx + 1);
                end
                nx++;
                if (nx == 9) begin
                    bus.cmd = 8'h00;
                    bus.cmd_valid = 1'b1;
                end
            end
        end
        checks++;
        if (nx != 9 || ndone != 8 / PASS_LEN) begin
            failures++;
            $display("FAIL loop_count got transfers=%0d dones=%0d exp transfers=9 dones=%0d", nx, ndone, 8 / PASS_LEN);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_data !== 8'h00) begin
            failures++;
            $display("FAIL abort_idle got valid=%b busy=%b done=%b data=%h exp 0 0 0 00",
                     bus.out_valid, bus.busy, bus.done, bus.out_data);
        end
        repeat (6) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL abort_quiet got activity after abort exp none");
        end
    endtask

    task automatic test_ena();
        int nx = 0, hold_left = 0, done_cyc = -1;
        bit held = 0;
        logic [7:0] e;
        bit ok;
        sb.delete();
        push_bytes(PASS_LEN);
        bus.out_ready = 1'b1;
        bus.cmd = 8'h01;
        bus.cmd_valid = 1'b1;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (hold_left == 0 && !held && bus.out_valid === 1'b1 && bus.out_data === 8'h52) hold_left = 4;
            if (bus.done === 1'b1) done_cyc = cyc;
            if (hold_left > 0) begin
                ena = 1'b0;
                if (hold_left == 4) begin
                    bus.cmd = 8'h00;
                    bus.cmd_valid = 1'b1;
                end
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h52 || bus.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL ena_freeze got valid=%b data=%h busy=%b exp 1 52 1",
                             bus.out_valid, bus.out_data, bus.busy);
                end
                hold_left--;
                if (hold_left == 0) held = 1;
            end else begin
                ena = 1'b1;
                if (bus.out_valid === 1'b1) begin
                    pop_exp(e, ok);
                    checks++;
                    if (!ok || bus.out_data !== e) begin
                        failures++;
                        $display("FAIL ena_byte got %h exp %h", bus.out_data, e);
                    end
                    nx++;
                end
            end
        end
        ena = 1'b1;
        checks++;
        if (!held || done_cyc < 0 || nx != PASS_LEN) begin
            failures++;
            $display("FAIL ena_count got bytes=%0d held=%0d done_cycle=%0d exp bytes=%0d held=1 with done",
                     nx, held, done_cyc, PASS_LEN);
        end
    endtask

    task automatic test_reset_midstream();
        bit did_reset = 0, strobed = 0;
        logic [7:0] e;
        bit ok;
        sb.delete();
        push_bytes(PASS_LEN);
        bus.out_ready = 1'b1;
        bus.cmd = 8'h01;
        bus.cmd_valid = 1'b1;
        for (int cyc = 1; cyc <= 40 && !did_reset; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (bus.out_valid === 1'b1) begin
                pop_exp(e, ok);
                checks++;
                if (!ok || bus.out_data !== e) begin
                    failures++;
                    $display("FAIL rst_byte got %h exp %h", bus.out_data, e);
                end
                if (bus.out_data === 8'h52 && !strobed) begin
                    strobed = 1;
                    bus.cmd = 8'h01;
                    bus.cmd_valid = 1'b1;
                end else if (bus.out_data === 8'h54) begin
                    did_reset = 1;
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                        failures++;
                        $display("FAIL rst_immediate got valid=%b data=%h busy=%b done=%b exp all 0",
                                 bus.out_valid, bus.out_data, bus.busy, bus.done);
                    end
                end
            end
        end
        checks++;
        if (!did_reset) begin
            failures++;
            $display("FAIL rst_reached got no byte 54 exp byte 54 then reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL rst_stays_idle got valid=%b busy=%b done=%b exp 0 0 0", bus.out_valid, bus.busy, bus.done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_backpressure();
        test_loop_abort();
        test_ena();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
